idx_set_builder: RTL

IDX_SET_BUILDER -- requirements
Module: idx_set_builder

---
 rtl/idx_set_builder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/idx_set_builder.sv
// idx_set_builder: rebuilds a WIDTH-bit set vector from a stream of bit
// indices (one beat per set bit, in_last marks the final beat). The finished
// set is presented with its population count and sticky duplicate /
// out-of-range flags, and held until the consumer takes it.
//
// Handshake rule for both sides: a beat transfers on a rising edge of ck
// where valid and ready are both 1; the sender keeps valid and payload
// stable until then, and ready never depends combinationally on valid.
module idx_set_builder #(
   parameter  int WIDTH = 16,
   localparam int IDXW  = $clog2(WIDTH)
) (
   input  logic              ck,
   input  logic              rst_n,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [IDXW-1:0]   in_idx,
   input  logic              in_last,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [WIDTH-1:0]  out_mask,
   output logic [IDXW:0]     out_cnt,
   output logic              out_dup,
   output logic              out_oob
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   // WIDTH expressed in the index width plus one, so indices past a
   // non-power-of-two width can be recognised.
   localparam logic [IDXW:0] WIDTH_C = (IDXW+1)'(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] mask_q,  mask_d;
   logic [IDXW:0]    cnt_q,   cnt_d;
   logic             dup_q,   dup_d;
   logic             oob_q,   oob_d;

   logic             accept;
   logic             hold;
   logic             is_oob;
   logic             is_dup;
   logic [WIDTH-1:0] onehot;

   // Beat classification and next-state / accumulator update.
   always_comb begin
      hold    = (state_q == ST_HOLD);
      accept  = in_vld && !hold;
      // An out-of-range index shifts the one past the top and decodes to zero.
      onehot  = WIDTH'(1) << in_idx;
      is_oob  = ({1'b0, in_idx} >= WIDTH_C);
      is_dup  = !is_oob && (|(mask_q & onehot));

      state_d = state_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      dup_d   = dup_q;
      oob_d   = oob_q;

      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (accept) begin
               if (is_oob) begin
                  oob_d = 1'b1;
               end else if (is_dup) begin
                  dup_d = 1'b1;
               end else begin
                  mask_d = mask_q | onehot;
                  // Only clear bits are counted, so the count tops out at WIDTH.
                  cnt_d  = cnt_q + (IDXW+1)'(1);
               end
               state_d = in_last ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_HOLD: begin
            if (out_rdy) begin
               // Set consumed: start the next one from an empty accumulator.
               mask_d  = '0;
               cnt_d   = '0;
               dup_d   = 1'b0;
               oob_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and accumulator registers; reset discards any partial or held set.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         cnt_q   <= '0;
         dup_q   <= 1'b0;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         dup_q   <= dup_d;
         oob_q   <= oob_d;
      end
   end

   // Outputs read zero unless a completed set is being held.
   always_comb begin
      in_rdy   = !hold;
      out_vld  = hold;
      out_mask = hold ? mask_q : '0;
      out_cnt  = hold ? cnt_q  : '0;
      out_dup  = hold ? dup_q  : 1'b0;
      out_oob  = hold ? oob_q  : 1'b0;
   end

endmodule
